// File: rtl/alu_issue_wb.sv
// Issue/writeback pipeline around an external combinational ALU: an EX stage drives the ALU,
// a WB stage holds its result until the consumer takes it and the register file is written.
module alu_issue_wb #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs,
  input  logic [2:0]   in_rt,
  input  logic         in_imm_sel,
  input  logic [W-1:0] in_imm,
  output logic [W-1:0] alu_r2,
  output logic [W-1:0] alu_r3,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_r0,
  output logic         wb_valid,
  output logic [2:0]   wb_addr,
  output logic [W-1:0] wb_data,
  input  logic         out_ready,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  logic [W-1:0] rf [8];
  logic         ex_valid;
  logic [2:0]   ex_rd;
  logic         wb_fire, wb_free, ex_move, accept;
  logic [W-1:0] op_a, op_b;

  assign wb_fire  = wb_valid & out_ready;
  assign wb_free  = ~wb_valid | out_ready;
  assign ex_move  = ex_valid & wb_free;
  assign in_ready = ~rst & (~ex_valid | wb_free);
  assign accept   = in_valid & in_ready;
  assign dbg_data = rf[dbg_addr];

  // EX result is the youngest in flight, so it wins over the WB result.
  always_comb begin
    op_a = rf[in_rs];
    if (ex_valid && ex_rd == in_rs) begin
      op_a = alu_r0;
    end else if (wb_valid && wb_addr == in_rs) begin
      op_a = wb_data;
    end
    if (in_imm_sel) begin
      op_a = in_imm;
    end

    op_b = rf[in_rt];
    if (ex_valid && ex_rd == in_rt) begin
      op_b = alu_r0;
    end else if (wb_valid && wb_addr == in_rt) begin
      op_b = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      alu_r2   <= '0;
      alu_r3   <= '0;
      alu_op   <= '0;
      ex_rd    <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      alu_r2   <= op_a;
      alu_r3   <= op_b;
      alu_op   <= in_op;
      ex_rd    <= in_rd;
    end else if (ex_move) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (ex_move) begin
      wb_valid <= 1'b1;
      wb_addr  <= ex_rd;
      wb_data  <= alu_r0;
    end else if (wb_fire) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_fire) begin
      rf[wb_addr] <= wb_data;
    end
  end

endmodule
